// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron core: one Euler step for every neuron per
// step request, one neuron per clock through a fetch / compute / emit pipeline.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   step_start / busy / step_done    step handshake
//   cur_idx, cur_req / cur_data      current RAM read (data one cycle after req)
//   spike_valid, spike_idx           spike index stream, ascending order
//   cfg_we, cfg_idx, cfg_sel, cfg_data  idle-time parameter/state writes
module izh_neuron_array #(
   parameter int WIDTH     = 32,
   parameter int FRAC      = 16,
   parameter int N_NEURONS = 16,
   parameter int DT_SHIFT  = 3,
   parameter int V_PEAK    = 30,
   parameter int REFRAC    = 0,
   localparam int unsigned IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    step_start,
   output logic                    busy,
   output logic                    step_done,
   output logic [IW-1:0]           cur_idx,
   output logic                    cur_req,
   input  logic signed [WIDTH-1:0] cur_data,
   output logic                    spike_valid,
   output logic [IW-1:0]           spike_idx,
   input  logic                    cfg_we,
   input  logic [IW-1:0]           cfg_idx,
   input  logic [2:0]              cfg_sel,
   input  logic signed [WIDTH-1:0] cfg_data
);
   localparam int unsigned RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int unsigned PW  = 2 * WIDTH;
   localparam longint      ONE = longint'(1) << FRAC;

   localparam logic signed [WIDTH-1:0] MAX_W  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
   // Reset and model constants, rounded to nearest at FRAC
   localparam logic signed [WIDTH-1:0] K_A    = WIDTH'((2 * ONE + 50) / 100);
   localparam logic signed [WIDTH-1:0] K_B    = WIDTH'((2 * ONE + 5) / 10);
   localparam logic signed [WIDTH-1:0] K_C    = WIDTH'(-65 * ONE);
   localparam logic signed [WIDTH-1:0] K_D    = WIDTH'(8 * ONE);
   localparam logic signed [WIDTH-1:0] K_W0   = WIDTH'(-13 * ONE);
   localparam logic signed [WIDTH-1:0] K_Q    = WIDTH'((2 * ONE + 25) / 50);
   localparam logic signed [WIDTH-1:0] K_5    = WIDTH'(5 * ONE);
   localparam logic signed [WIDTH-1:0] K_140  = WIDTH'(140 * ONE);
   localparam logic signed [WIDTH-1:0] K_PEAK = WIDTH'(longint'(V_PEAK) * ONE);

   function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] y);
      logic signed [WIDTH:0] s;
      s = (WIDTH+1)'(x) + (WIDTH+1)'(y);
      if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MIN_W : MAX_W;
      return s[WIDTH-1:0];
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [WIDTH-1:0] y);
      logic signed [WIDTH:0] s;
      s = (WIDTH+1)'(x) - (WIDTH+1)'(y);
      if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MIN_W : MAX_W;
      return s[WIDTH-1:0];
   endfunction

   // Full-precision product rescaled by FRAC, clamped back into WIDTH
   function automatic logic signed [WIDTH-1:0] mul(input logic signed [WIDTH-1:0] x,
                                                   input logic signed [WIDTH-1:0] y);
      logic signed [PW-1:0] p;
      p = (PW'(x) * PW'(y)) >>> FRAC;
      if (!((&p[PW-1:WIDTH-1]) || !(|p[PW-1:WIDTH-1]))) return p[PW-1] ? MIN_W : MAX_W;
      return p[WIDTH-1:0];
   endfunction

   logic                    busy_q, busy_d, cur_req_q, cur_req_d;
   logic [IW-1:0]           cur_idx_q, cur_idx_d, s2_idx_q, s2_idx_d, spike_idx_q, spike_idx_d;
   logic                    s2_valid_q, s2_valid_d, spike_valid_q, spike_valid_d;
   logic                    last_q, last_d, step_done_q, step_done_d;
   logic signed [WIDTH-1:0] a_q [N_NEURONS], a_d [N_NEURONS], b_q [N_NEURONS], b_d [N_NEURONS];
   logic signed [WIDTH-1:0] c_q [N_NEURONS], c_d [N_NEURONS], d_q [N_NEURONS], d_d [N_NEURONS];
   logic signed [WIDTH-1:0] v_q [N_NEURONS], v_d [N_NEURONS], w_q [N_NEURONS], w_d [N_NEURONS];
   logic [RW-1:0]           ref_q [N_NEURONS], ref_d [N_NEURONS];

   logic signed [WIDTH-1:0] v_old, w_old, dv, dw, v_t, w_t, v_new, w_new;
   logic [RW-1:0]           ref_old, ref_new;
   logic                    fire;

   // Compute stage: Euler update of the neuron fetched last cycle
   always_comb begin
      v_old   = v_q[s2_idx_q];
      w_old   = w_q[s2_idx_q];
      ref_old = ref_q[s2_idx_q];
      dv      = sat_add(mul(mul(v_old, v_old), K_Q), mul(v_old, K_5));
      dv      = sat_add(dv, K_140);
      dv      = sat_sub(dv, w_old);
      dv      = sat_add(dv, cur_data);
      dw      = mul(a_q[s2_idx_q], sat_sub(mul(b_q[s2_idx_q], v_old), w_old));
      v_t     = sat_add(v_old, dv >>> DT_SHIFT);
      w_t     = sat_add(w_old, dw >>> DT_SHIFT);
      fire    = 1'b0;
      v_new   = v_t;
      w_new   = w_t;
      ref_new = ref_old;
      if (ref_old != '0) begin
         // Refractory: clamp v, let w evolve, discard the current's effect on firing
         v_new   = c_q[s2_idx_q];
         ref_new = ref_old - RW'(1);
      end else if (v_t > K_PEAK) begin
         fire    = 1'b1;
         v_new   = c_q[s2_idx_q];
         w_new   = sat_add(w_old, d_q[s2_idx_q]);
         ref_new = RW'(REFRAC);
      end
   end

   // Sequencing, config writes and write-back
   always_comb begin
      busy_d        = busy_q;
      cur_req_d     = cur_req_q;
      cur_idx_d     = cur_idx_q;
      s2_valid_d    = cur_req_q;
      s2_idx_d      = cur_idx_q;
      spike_valid_d = 1'b0;
      spike_idx_d   = spike_idx_q;
      last_d        = 1'b0;
      step_done_d   = last_q;
      a_d = a_q;  b_d = b_q;  c_d = c_q;  d_d = d_q;
      v_d = v_q;  w_d = w_q;  ref_d = ref_q;

      if (!busy_q) begin
         if (step_start) begin
            busy_d    = 1'b1;
            cur_req_d = 1'b1;
            cur_idx_d = '0;
         end
         if (cfg_we && (int'(cfg_idx) < N_NEURONS)) begin
            case (cfg_sel)
               3'd0:    a_d[cfg_idx] = cfg_data;
               3'd1:    b_d[cfg_idx] = cfg_data;
               3'd2:    c_d[cfg_idx] = cfg_data;
               3'd3:    d_d[cfg_idx] = cfg_data;
               3'd4:    v_d[cfg_idx] = cfg_data;
               3'd5:    w_d[cfg_idx] = cfg_data;
               default: ;
            endcase
         end
      end else begin
         if (cur_req_q) begin
            if (cur_idx_q == IW'(N_NEURONS - 1)) cur_req_d = 1'b0;
            else                                 cur_idx_d = cur_idx_q + IW'(1);
         end
         // busy stays high through the step_done cycle
         if (step_done_q) busy_d = 1'b0;
      end

      if (s2_valid_q) begin
         v_d[s2_idx_q]   = v_new;
         w_d[s2_idx_q]   = w_new;
         ref_d[s2_idx_q] = ref_new;
         spike_valid_d   = fire;
         if (fire) spike_idx_d = s2_idx_q;
         last_d = (s2_idx_q == IW'(N_NEURONS - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q        <= 1'b0;
         cur_req_q     <= 1'b0;
         cur_idx_q     <= '0;
         s2_valid_q    <= 1'b0;
         s2_idx_q      <= '0;
         spike_valid_q <= 1'b0;
         spike_idx_q   <= '0;
         last_q        <= 1'b0;
         step_done_q   <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            a_q[i]   <= K_A;
            b_q[i]   <= K_B;
            c_q[i]   <= K_C;
            d_q[i]   <= K_D;
            v_q[i]   <= K_C;
            w_q[i]   <= K_W0;
            ref_q[i] <= '0;
         end
      end else begin
         busy_q        <= busy_d;
         cur_req_q     <= cur_req_d;
         cur_idx_q     <= cur_idx_d;
         s2_valid_q    <= s2_valid_d;
         s2_idx_q      <= s2_idx_d;
         spike_valid_q <= spike_valid_d;
         spike_idx_q   <= spike_idx_d;
         last_q        <= last_d;
         step_done_q   <= step_done_d;
         a_q <= a_d;  b_q <= b_d;  c_q <= c_d;  d_q <= d_d;
         v_q <= v_d;  w_q <= w_d;  ref_q <= ref_d;
      end
   end

   assign busy        = busy_q;
   assign step_done   = step_done_q;
   assign cur_idx     = cur_idx_q;
   assign cur_req     = cur_req_q;
   assign spike_valid = spike_valid_q;
   assign spike_idx   = spike_idx_q;

endmodule

// File: tb/tb_izh_neuron_array.sv
// Bench for izh_neuron_array: two instances (REFRAC=0 and REFRAC=2), each fed
// by its own current RAM model. Expected spikes/step_done are queued with their
// cycle when a step is launched; a negedge monitor pops and compares them.
module tb_izh_neuron_array;
   localparam int N  = 16;
   localparam int W  = 32;
   localparam int IW = 4;

   // Q16.16 constants used as expectations
   localparam longint C_RST  = -4259840;   // -65.0
   localparam longint W_RST  = -851968;    // -13.0
   localparam longint V29    = 1900544;    // 29.0
   localparam longint I100   = 6553600;    // 100.0
   localparam longint V20K   = 1310720000; // 20000.0
   localparam longint W_M5   = -327680;    // -13.0 + 8.0
   // One step from rest with I=0, using 0.04 rounded to 2621/65536:
   // dv = 11073725 - 21299200 + 9175040 + 851968 = -198467; >>>3 = -24809
   localparam longint V_STEP1 = -4284649;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic                step_start [2];
   logic                busy       [2];
   logic                step_done  [2];
   logic [IW-1:0]       cur_idx    [2];
   logic                cur_req    [2];
   logic signed [W-1:0] cur_data   [2];
   logic                spike_valid[2];
   logic [IW-1:0]       spike_idx  [2];
   logic                cfg_we     [2];
   logic [IW-1:0]       cfg_idx    [2];
   logic [2:0]          cfg_sel    [2];
   logic signed [W-1:0] cfg_data   [2];
   logic signed [W-1:0] cur_mem    [2][N];

   izh_neuron_array #(.REFRAC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .step_start(step_start[0]), .busy(busy[0]),
      .step_done(step_done[0]), .cur_idx(cur_idx[0]), .cur_req(cur_req[0]),
      .cur_data(cur_data[0]), .spike_valid(spike_valid[0]), .spike_idx(spike_idx[0]),
      .cfg_we(cfg_we[0]), .cfg_idx(cfg_idx[0]), .cfg_sel(cfg_sel[0]), .cfg_data(cfg_data[0]));

   izh_neuron_array #(.REFRAC(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .step_start(step_start[1]), .busy(busy[1]),
      .step_done(step_done[1]), .cur_idx(cur_idx[1]), .cur_req(cur_req[1]),
      .cur_data(cur_data[1]), .spike_valid(spike_valid[1]), .spike_idx(spike_idx[1]),
      .cfg_we(cfg_we[1]), .cfg_idx(cfg_idx[1]), .cfg_sel(cfg_sel[1]), .cfg_data(cfg_data[1]));

   // Current RAM: registered read, data valid the cycle after cur_req
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         cur_data[d] <= cur_req[d] ? cur_mem[d][cur_idx[d]] : '0;
   end

   int checks = 0;
   int errors = 0;

   typedef struct { int cyc; int done; int idx; } ev_t;
   ev_t q0[$];
   ev_t q1[$];

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic qpush(input int d, input ev_t e);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic qpop(input int d, output ev_t e);
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_ev(input int d, input int done, input int idx);
      ev_t e;
      checks++;
      if (qsize(d) == 0) begin
         errors++;
         $display("FAIL dut%0d_event: got cyc=%0d done=%0d idx=%0d expected no event", d, cyc, done, idx);
      end else begin
         qpop(d, e);
         if (e.cyc != cyc || e.done != done || e.idx != idx) begin
            errors++;
            $display("FAIL dut%0d_event: got cyc=%0d done=%0d idx=%0d expected cyc=%0d done=%0d idx=%0d",
                     d, cyc, done, idx, e.cyc, e.done, e.idx);
         end
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (spike_valid[d]) check_ev(d, 0, int'(spike_idx[d]));
            if (step_done[d])   check_ev(d, 1, 0);
         end
      end
   end

   task automatic set_cur(input int d, input longint val);
      for (int k = 0; k < N; k++) cur_mem[d][k] = W'(val);
   endtask

   task automatic cfg(input int d, input int idx, input int sel, input longint val);
      @(negedge clk);
      cfg_we[d]   = 1'b1;
      cfg_idx[d]  = IW'(idx);
      cfg_sel[d]  = 3'(sel);
      cfg_data[d] = W'(val);
      @(negedge clk);
      cfg_we[d]   = 1'b0;
   endtask

   // Launch a step; mask bit k means neuron k is expected to fire
   task automatic start_step(input int d, input int mask, output int t0);
      ev_t e;
      @(negedge clk);
      chk($sformatf("dut%0d_busy_T0", d), longint'(busy[d]), 0);
      step_start[d] = 1'b1;
      t0 = cyc;
      for (int k = 0; k < N; k++) begin
         if (mask[k]) begin
            e.cyc = t0 + 3 + k; e.done = 0; e.idx = k;
            qpush(d, e);
         end
      end
      e.cyc = t0 + 3 + N; e.done = 1; e.idx = 0;
      qpush(d, e);
      @(negedge clk);
      step_start[d] = 1'b0;
      chk($sformatf("dut%0d_busy_T1", d), longint'(busy[d]), 1);
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      while (busy[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("dut%0d_idle_bound", d), longint'(busy[d]), 0);
      repeat (3) @(negedge clk);
      chk($sformatf("dut%0d_events_drained", d), longint'(qsize(d)), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int t0;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         step_start[d] = 1'b0; cfg_we[d] = 1'b0; cfg_idx[d] = '0;
         cfg_sel[d] = '0; cfg_data[d] = '0;
         set_cur(d, 0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_busy", longint'(busy[0]), 0);
      chk("rst_cur_req", longint'(cur_req[0]), 0);
      chk("rst_cur_idx", longint'(cur_idx[0]), 0);
      chk("rst_spike_valid", longint'(spike_valid[0]), 0);
      chk("rst_spike_idx", longint'(spike_idx[0]), 0);
      chk("rst_step_done", longint'(step_done[0]), 0);
      chk("rst_a", longint'(u_dut0.a_q[5]), 1311);
      chk("rst_b", longint'(u_dut0.b_q[5]), 13107);
      chk("rst_c", longint'(u_dut0.c_q[5]), C_RST);
      chk("rst_d", longint'(u_dut0.d_q[5]), 524288);
      chk("rst_v", longint'(u_dut0.v_q[5]), C_RST);
      chk("rst_w", longint'(u_dut0.w_q[5]), W_RST);

      // Rest state, I=0: timing of busy/step_done and one-step values
      start_step(0, 0, t0);
      while (cyc < t0 + 3 + N) @(negedge clk);
      chk("s1_busy_at_done", longint'(busy[0]), 1);
      @(negedge clk);
      chk("s1_busy_after_done", longint'(busy[0]), 0);
      wait_idle(0);
      chk("s1_v0", longint'(u_dut0.v_q[0]), V_STEP1);
      chk("s1_w0", longint'(u_dut0.w_q[0]), W_RST);
      chk("s1_v15", longint'(u_dut0.v_q[15]), V_STEP1);

      // Neuron 3 pushed near threshold with I=100: only it fires, at T0+6
      set_cur(0, I100);
      cfg(0, 3, 4, V29);
      start_step(0, 16'h0008, t0);
      wait_idle(0);
      chk("s2_v3", longint'(u_dut0.v_q[3]), C_RST);
      chk("s2_w3", longint'(u_dut0.w_q[3]), W_M5);

      // v=20000: v*v saturates positive, neuron 1 must fire
      set_cur(0, 0);
      cfg(0, 1, 4, V20K);
      start_step(0, 16'h0002, t0);
      wait_idle(0);
      chk("s3_v1", longint'(u_dut0.v_q[1]), C_RST);

      // step_start and cfg_we pulsed mid-step are both ignored
      start_step(0, 0, t0);
      @(negedge clk);
      @(negedge clk);
      step_start[0] = 1'b1;
      cfg_we[0] = 1'b1; cfg_idx[0] = IW'(12); cfg_sel[0] = 3'd4; cfg_data[0] = W'(V29);
      @(negedge clk);
      step_start[0] = 1'b0;
      cfg_we[0] = 1'b0;
      wait_idle(0);
      chk("s5_v12_not_written", longint'(u_dut0.v_q[12] == W'(V29)), 0);
      chk("s5_still_idle", longint'(busy[0]), 0);

      // Reset in the middle of a step
      start_step(0, 0, t0);
      while (cyc < t0 + 5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", longint'(busy[0]), 0);
      chk("mid_rst_cur_req", longint'(cur_req[0]), 0);
      chk("mid_rst_cur_idx", longint'(cur_idx[0]), 0);
      chk("mid_rst_spike_valid", longint'(spike_valid[0]), 0);
      q0.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_v3", longint'(u_dut0.v_q[3]), C_RST);
      chk("mid_rst_w3", longint'(u_dut0.w_q[3]), W_RST);
      chk("mid_rst_v1", longint'(u_dut0.v_q[1]), C_RST);
      repeat (25) @(negedge clk);
      chk("mid_rst_no_busy", longint'(busy[0]), 0);
      start_step(0, 0, t0);
      wait_idle(0);
      chk("post_rst_v0", longint'(u_dut0.v_q[0]), V_STEP1);
      chk("post_rst_w0", longint'(u_dut0.w_q[0]), W_RST);

      // Refractory instance: force a spike, then two clamped steps, then fire again
      set_cur(1, I100);
      cfg(1, 0, 4, V29);
      start_step(1, 16'h0001, t0);
      wait_idle(1);
      chk("rf_v0_fire", longint'(u_dut1.v_q[0]), C_RST);
      chk("rf_count", longint'(u_dut1.ref_q[0]), 2);
      for (int s = 1; s <= 2; s++) begin
         cfg(1, 0, 4, V29);
         start_step(1, 0, t0);
         wait_idle(1);
         chk($sformatf("rf_v0_clamped_step%0d", s), longint'(u_dut1.v_q[0]), C_RST);
      end
      chk("rf_count_done", longint'(u_dut1.ref_q[0]), 0);
      cfg(1, 0, 4, V29);
      start_step(1, 16'h0001, t0);
      wait_idle(1);
      chk("rf_v0_refire", longint'(u_dut1.v_q[0]), C_RST);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
